fetch_stage: RTL

Instruction-fetch stage of the 16-bit five-stage pipeline CPU: owns the 8-bit program counter, the PC+2 adder and the IF/ID pipeline buffer. It presents the PC to the instruction memory and captures the returned word together with PC+2. It also applies the stall, flush and redirect requests coming from the decode stage and the hazard unit. It feeds the decode stage directly and is the first sequential stage the top-level `cpu` instance clocks.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/pc_adder.sv | 9 +
 rtl/fetch_stage.sv | 65 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and encodings used by the pipeline stages.
package cpu_pkg;
  localparam int          PC_W        = 8;
  localparam int          INSTR_W     = 16;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam logic [15:0] NOP_INSTR   = 16'h0000;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_adder.sv
// PC+2 incrementer; wraps modulo 2^W with no carry out.
module pc_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] pc,
  output logic [W-1:0] pc_plus2
);
  assign pc_plus2 = pc + W'(2);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+2 adder and IF/ID buffer with
// stall, redirect and HALT handling.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                PC_W        = cpu_pkg::PC_W,
  parameter int                INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [3:0]        HALT_OPCODE = cpu_pkg::HALT_OPCODE,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(cpu_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);
  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus2;
  logic            is_halt;

  pc_adder #(.W(PC_W)) u_pc_adder (
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  assign imem_addr = pc;
  assign halted    = (state == FS_HALTED);
  assign is_halt   = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

  // Priority: rst > redirect > HALTED > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FS_RUN;
      pc             <= '0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else if (redirect) begin
      state          <= FS_RUN;
      pc             <= {redirect_pc[PC_W-1:1], 1'b0};
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
    end else if (state == FS_HALTED) begin
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_instr    <= imem_data;
      if_id_pc_plus2 <= pc_plus2;
      if_id_valid    <= 1'b1;
      if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      // HALT is latched so it retires, but the PC stays on it.
      if (is_halt) state <= FS_HALTED;
      else         pc    <= pc_plus2;
    end
  end
endmodule
